// File: rtl/tpu_pkg.sv
// Shared TPU types and default sizing: sequencer state encoding, array
// geometry and the wavefront drain length.
package tpu_pkg;

    localparam int unsigned TPU_ARRAY_SIZE = 4;
    localparam int unsigned TPU_K_MAX      = 16;
    localparam int unsigned TPU_DRAIN_LEN  = 3 * TPU_ARRAY_SIZE - 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        WRITEBACK,
        DONE
    } seq_state_t;

    // Cycles for the last operand to cross an n x n array and settle.
    function automatic int unsigned drain_cycles(input int unsigned n);
        return 3 * n - 1;
    endfunction

endpackage

// File: rtl/matmul_sequencer_skew_line.sv
// skew_line: STAGES-deep 1-bit shift register with synchronous clear;
// tap i is the input delayed by i+1 cycles.
module skew_line #(
    parameter int unsigned STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              din,
    output logic [STAGES-1:0] dout
);

    logic [STAGES-1:0] line_q;
    logic [STAGES-1:0] line_d;

    always_comb begin
        line_d = '0;
        if (!clr) begin
            line_d = (line_q << 1) | STAGES'(din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign dout = line_q;

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: cycle-accurate schedule for one systolic matrix multiply
// (clear, feed, drain, write-back). Optional cycle counter: TPU_SEQ_PERF_EN.
module matmul_sequencer
    import tpu_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = TPU_ARRAY_SIZE,
    parameter int unsigned K_MAX      = TPU_K_MAX,
    parameter int unsigned ADDR_W     = $clog2(K_MAX)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len,
    output logic                          busy,
    output logic                          done,
    output logic                          acc_clr,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             rd_addr,
    output logic [ARRAY_SIZE-1:0]         lane_en_top,
    output logic [ARRAY_SIZE-1:0]         lane_en_left,
    output logic                          matmul,
    output logic                          wb_en,
    output logic [$clog2(ARRAY_SIZE)-1:0] wb_row
`ifdef TPU_SEQ_PERF_EN
   ,output logic [31:0]                   perf_cycles
`endif
);

    localparam int unsigned KLEN_W    = $clog2(K_MAX + 1);
    localparam int unsigned WB_W      = $clog2(ARRAY_SIZE);
    localparam int unsigned DRAIN_LEN = drain_cycles(ARRAY_SIZE);
    localparam int unsigned CNT_MAX   = (K_MAX > DRAIN_LEN)
                                        ? ((K_MAX > ARRAY_SIZE) ? K_MAX : ARRAY_SIZE)
                                        : ((DRAIN_LEN > ARRAY_SIZE) ? DRAIN_LEN : ARRAY_SIZE);
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [KLEN_W-1:0]   k_eff_q, k_eff_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                acc_clr_q, acc_clr_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                matmul_q, matmul_d;
    logic                wb_en_q, wb_en_d;
    logic [WB_W-1:0]     wb_row_q, wb_row_d;

    logic                accept;
    logic [KLEN_W-1:0]   k_sat;
    logic [CNT_W-1:0]    feed_last;

    assign accept    = (state_q == IDLE) && start;
    assign k_sat     = (k_len > KLEN_W'(K_MAX)) ? KLEN_W'(K_MAX) : k_len;
    assign feed_last = CNT_W'(k_eff_q) - CNT_W'(1);

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_eff_d = k_eff_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    k_eff_d = k_sat;
                    state_d = (k_sat == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt_q == feed_last) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
                    state_d = WRITEBACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITEBACK: begin
                if (cnt_q == CNT_W'(ARRAY_SIZE - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        acc_clr_d = (state_d == CLEAR);
        rd_en_d   = (state_d == FEED);
        matmul_d  = (state_d == FEED) || (state_d == DRAIN);
        wb_en_d   = (state_d == WRITEBACK);
        rd_addr_d = (state_d == FEED) ? ADDR_W'(cnt_d) : rd_addr_q;
        wb_row_d  = (state_d == WRITEBACK) ? WB_W'(cnt_d) : wb_row_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            k_eff_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            matmul_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_row_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_eff_q   <= k_eff_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            acc_clr_q <= acc_clr_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            matmul_q  <= matmul_d;
            wb_en_q   <= wb_en_d;
            wb_row_q  <= wb_row_d;
        end
    end

    // Both edges see the same read strobe; the buffers share one read latency.
    skew_line #(.STAGES(ARRAY_SIZE)) u_skew_top (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr_q),
        .din  (rd_en_q),
        .dout (lane_en_top)
    );

    skew_line #(.STAGES(ARRAY_SIZE)) u_skew_left (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr_q),
        .din  (rd_en_q),
        .dout (lane_en_left)
    );

`ifdef TPU_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign acc_clr = acc_clr_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign matmul  = matmul_q;
    assign wb_en   = wb_en_q;
    assign wb_row  = wb_row_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Testbench for matmul_sequencer: reference schedule computed from cycle
// formulas, random k_len runs, ignored starts and mid-run reset.
module tb_matmul_sequencer;

    localparam int N     = 4;
    localparam int K_MAX = 16;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       acc_clr;
        logic       rd_en;
        logic       matmul;
        logic       wb_en;
        logic [3:0] rd_addr;
        logic [1:0] wb_row;
        logic [3:0] top;
        logic [3:0] left;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] k_len;
    logic       busy, done, acc_clr, rd_en, matmul, wb_en;
    logic [3:0] rd_addr;
    logic [3:0] lane_en_top, lane_en_left;
    logic [1:0] wb_row;
`ifdef TPU_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matmul_sequencer #(
        .ARRAY_SIZE (N),
        .K_MAX      (K_MAX),
        .ADDR_W     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .busy         (busy),
        .done         (done),
        .acc_clr      (acc_clr),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .lane_en_top  (lane_en_top),
        .lane_en_left (lane_en_left),
        .matmul       (matmul),
        .wb_en        (wb_en),
        .wb_row       (wb_row)
`ifdef TPU_SEQ_PERF_EN
       ,.perf_cycles  (perf_cycles)
`endif
    );

    function automatic obs_t observe();
        obs_t o;
        o = {busy, done, acc_clr, rd_en, matmul, wb_en, rd_addr, wb_row,
             lane_en_top, lane_en_left};
        return o;
    endfunction

    // Expected outputs c cycles after the accepting edge, for effective length k.
    function automatic obs_t model(input int k, input int c);
        obs_t o;
        int   done_c;
        o = '0;
        done_c = (k == 0) ? 1 : k + 4 * N + 1;
        o.busy = (c >= 1) && (c <= done_c);
        o.done = (c == done_c);
        if (k > 0) begin
            o.acc_clr = (c == 1);
            o.rd_en   = (c >= 2) && (c <= k + 1);
            o.matmul  = (c >= 2) && (c <= k + 3 * N);
            o.wb_en   = (c >= k + 3 * N + 1) && (c <= k + 4 * N);
            if (o.rd_en) o.rd_addr = 4'(c - 2);
            if (o.wb_en) o.wb_row  = 2'(c - (k + 3 * N + 1));
            for (int i = 0; i < N; i++) begin
                o.top[i]  = (c >= 3 + i) && (c <= k + 2 + i);
                o.left[i] = (c >= 3 + i) && (c <= k + 2 + i);
            end
        end
        return o;
    endfunction

    // One operation: extra starts at cycles sa/sb, reset at cycle rst_at (0 = none).
    task automatic run_schedule(input int kl, input int sa, input int sb,
                                input int rst_at, input string tag);
        int   k, done_c, last_c, ndone, nrd;
        obs_t o, e, m;
        k      = (kl > K_MAX) ? K_MAX : kl;
        done_c = (k == 0) ? 1 : k + 4 * N + 1;
        last_c = (rst_at > 0) ? rst_at : done_c + 2;
        ndone  = 0;
        nrd    = 0;
        @(negedge clk);
        start = 1'b1;
        k_len = 5'(kl);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            o = observe();
            e = model(k, c);
            m = '1;
            if (!e.rd_en) m.rd_addr = '0;
            if (!e.wb_en) m.wb_row  = '0;
            n_checks++;
            if (((o ^ e) & m) !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs %h, required %h (mask %h)",
                         tag, c, o, e, m);
            end
`ifdef TPU_SEQ_PERF_EN
            n_checks++;
            if (perf_cycles !== 32'((c - 1 < done_c) ? c - 1 : done_c)) begin
                n_fail++;
                $display("FAIL %s perf cycle %0d: got %0d, required %0d", tag, c,
                         perf_cycles, (c - 1 < done_c) ? c - 1 : done_c);
            end
`endif
            if (o.done) ndone++;
            if (o.rd_en) nrd++;
            start = (c == sa) || (c == sb);
            k_len = 5'($urandom_range(1, 31));
            rst   = (c == rst_at);
            @(posedge clk);
            #1;
            start = 1'b0;
            rst   = 1'b0;
        end
        if (rst_at > 0) begin
            n_checks++;
            if (observe() !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL %s after reset: outputs %h, required 0", tag, observe());
            end
`ifdef TPU_SEQ_PERF_EN
            n_checks++;
            if (perf_cycles !== 32'd0) begin
                n_fail++;
                $display("FAIL %s perf after reset: got %0d, required 0", tag, perf_cycles);
            end
`endif
        end else begin
            n_checks++;
            if (ndone != 1 || nrd != k) begin
                n_fail++;
                $display("FAIL %s pulse counts: done=%0d rd_en=%0d, required done=1 rd_en=%0d",
                         tag, ndone, nrd, k);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        k_len = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (observe() !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset outputs: got %h, required 0", observe());
        end
`ifdef TPU_SEQ_PERF_EN
        n_checks++;
        if (perf_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset perf: got %0d, required 0", perf_cycles);
        end
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        run_schedule(4, 0, 0, 0, "basic_k4");
        repeat (3) @(posedge clk);
        #1;
`ifdef TPU_SEQ_PERF_EN
        n_checks++;
        if (perf_cycles !== 32'd21) begin
            n_fail++;
            $display("FAIL perf hold: got %0d, required 21", perf_cycles);
        end
`endif
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle after basic: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_zero();
        run_schedule(0, 0, 0, 0, "k_zero");
    endtask

    task automatic test_saturate();
        run_schedule(31, 0, 0, 0, "k_sat");
        n_checks++;
        if (rd_addr !== 4'd15) begin
            n_fail++;
            $display("FAIL sat rd_addr end: got %0d, required 15", rd_addr);
        end
    endtask

    task automatic test_ignore_start();
        // start during FEED (cycle 3) and during DONE (5 + 4N + 1)
        run_schedule(5, 3, 5 + 4 * N + 1, 0, "ignore_start");
    endtask

    task automatic test_reset_mid();
        run_schedule(3, 0, 0, 3 + 1 + 5, "rst_drain");
        @(posedge clk);
        #1;
        run_schedule(6, 0, 0, 0, "after_rst");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_schedule(int'($urandom_range(0, 31)), 0, 0, 0, "random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_saturate();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
